// File: rtl/mp3_pkg.sv
// Shared constants and state types for the MP3 sector fetch and frame-sync logic.
package mp3_pkg;

    localparam int          SECTOR_BYTES   = 512;
    localparam logic [7:0]  SYNC_BYTE      = 8'hFF;
    localparam logic [10:0] MIN_FRAME_SIZE = 11'd4;
    // Frame byte count at which the header size must already be known.
    localparam logic [10:0] HDR_DEADLINE   = 11'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_ISSUE,
        ST_STREAM,
        ST_DONE
    } fetch_state_t;

    typedef enum logic {
        SYNC_HUNT,
        SYNC_LOCK
    } sync_mode_t;

    function automatic logic is_sync_tail(input logic [7:0] b);
        return b[7:5] == 3'b111;
    endfunction

endpackage

// File: rtl/frame_tracker.sv
// Frame boundary tracker: hunts for the 0xFF/111x sync pair, then counts bytes
// against the header-supplied frame size and flags sync loss.
module frame_tracker
    import mp3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_byte_iv,
    input  logic [7:0]  i_byte_din,
    input  logic        i_header_iv,
    input  logic [10:0] i_frame_size,
    output logic        o_frame_start,
    output logic        o_frame_done,
    output logic        o_sync_err,
    output logic        o_plexer_rst
);

    sync_mode_t  r_mode;
    logic [10:0] r_fcnt;
    logic [10:0] r_size;
    logic        r_have_size;
    logic        r_prev_ff;
    logic        r_frame_start;
    logic        r_frame_done;
    logic        r_sync_err;
    logic        r_plexer_rst;

    sync_mode_t  w_mode_n;
    logic [10:0] w_fcnt_n;
    logic [10:0] w_size_n;
    logic        w_have_n;
    logic        w_prev_ff_n;
    logic        w_start_n;
    logic        w_done_n;
    logic        w_loss;

    // The byte is evaluated first with the old size; a same-cycle header is
    // applied afterwards, so it only counts if the tracker is locked after the byte.
    always_comb begin
        w_mode_n    = r_mode;
        w_fcnt_n    = r_fcnt;
        w_size_n    = r_size;
        w_have_n    = r_have_size;
        w_prev_ff_n = r_prev_ff;
        w_start_n   = 1'b0;
        w_done_n    = 1'b0;
        w_loss      = 1'b0;

        if (i_byte_iv) begin
            if (r_mode == SYNC_HUNT) begin
                if (r_prev_ff && is_sync_tail(i_byte_din)) begin
                    w_mode_n    = SYNC_LOCK;
                    w_fcnt_n    = 11'd2;
                    w_have_n    = 1'b0;
                    w_prev_ff_n = 1'b0;
                end else begin
                    w_prev_ff_n = (i_byte_din == SYNC_BYTE);
                end
            end else if (r_fcnt == 11'd0 && i_byte_din != SYNC_BYTE) begin
                w_loss = 1'b1;
            end else if (r_fcnt == HDR_DEADLINE && !r_have_size) begin
                w_loss = 1'b1;
            end else if (r_have_size && r_fcnt == r_size - 11'd1) begin
                w_done_n = 1'b1;
                w_fcnt_n = 11'd0;
                w_have_n = 1'b0;
            end else begin
                w_start_n = (r_fcnt == 11'd0);
                w_fcnt_n  = r_fcnt + 11'd1;
            end
        end

        if (w_loss) begin
            w_mode_n = SYNC_HUNT;
        end

        if (i_header_iv && w_mode_n == SYNC_LOCK) begin
            if (i_frame_size < MIN_FRAME_SIZE) begin
                w_loss   = 1'b1;
                w_mode_n = SYNC_HUNT;
            end else begin
                w_size_n = i_frame_size;
                w_have_n = 1'b1;
            end
        end

        if (w_loss) begin
            w_fcnt_n    = 11'd0;
            w_have_n    = 1'b0;
            w_prev_ff_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode        <= SYNC_HUNT;
            r_fcnt        <= 11'd0;
            r_size        <= 11'd0;
            r_have_size   <= 1'b0;
            r_prev_ff     <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_sync_err    <= 1'b0;
            r_plexer_rst  <= 1'b0;
        end else begin
            r_mode        <= w_mode_n;
            r_fcnt        <= w_fcnt_n;
            r_size        <= w_size_n;
            r_have_size   <= w_have_n;
            r_prev_ff     <= w_prev_ff_n;
            r_frame_start <= w_start_n;
            r_frame_done  <= w_done_n;
            r_sync_err    <= w_loss;
            r_plexer_rst  <= w_loss;
        end
    end

    assign o_frame_start = r_frame_start;
    assign o_frame_done  = r_frame_done;
    assign o_sync_err    = r_sync_err;
    assign o_plexer_rst  = r_plexer_rst;

endmodule

// File: rtl/mp3_frame_sequencer.sv
// Fetches the MP3 file sector by sector from the SD controller, forwards each
// byte to the demux and tracks frame boundaries on the forwarded stream.
module mp3_frame_sequencer
    import mp3_pkg::*;
#(
    parameter logic [31:0] START_ADDR  = 32'd0,
    parameter int          NUM_SECTORS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ds_ready,
    input  logic        sd_ready,
    input  logic        sd_byte_available,
    input  logic [7:0]  sd_dout,
    input  logic        header_iv,
    input  logic [10:0] frame_size,
    output logic        sd_rd,
    output logic [31:0] sd_addr,
    output logic        out_iv,
    output logic [7:0]  out_din,
    output logic        frame_start,
    output logic        frame_done,
    output logic        plexer_rst,
    output logic        sync_err,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] LAST_SECTOR = 32'(NUM_SECTORS - 1);
    localparam logic [8:0]  LAST_BYTE   = 9'(SECTOR_BYTES - 1);

    fetch_state_t r_state;
    logic [31:0]  r_sector_idx;
    logic [8:0]   r_byte_cnt;
    logic         r_sd_rd;
    logic [31:0]  r_sd_addr;
    logic         r_out_iv;
    logic [7:0]   r_out_din;
    logic         r_busy;
    logic         r_done;

    logic         w_byte_iv;

    // Bytes are only accepted while a sector read is in flight.
    assign w_byte_iv = (r_state == ST_STREAM) && sd_byte_available;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sector_idx <= 32'd0;
            r_byte_cnt   <= 9'd0;
            r_sd_rd      <= 1'b0;
            r_sd_addr    <= 32'd0;
            r_out_iv     <= 1'b0;
            r_out_din    <= 8'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_out_iv <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_GAP;
                        r_busy  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    // Only start a sector when the demux can take all of it.
                    if (ds_ready && sd_ready) begin
                        r_state   <= ST_ISSUE;
                        r_sd_rd   <= 1'b1;
                        r_sd_addr <= START_ADDR + {r_sector_idx[22:0], 9'd0};
                    end
                end
                ST_ISSUE: begin
                    if (!sd_ready) begin
                        r_state    <= ST_STREAM;
                        r_sd_rd    <= 1'b0;
                        r_byte_cnt <= 9'd0;
                    end
                end
                ST_STREAM: begin
                    if (sd_byte_available) begin
                        r_out_iv   <= 1'b1;
                        r_out_din  <= sd_dout;
                        r_byte_cnt <= r_byte_cnt + 9'd1;
                        if (r_byte_cnt == LAST_BYTE) begin
                            if (r_sector_idx == LAST_SECTOR) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state      <= ST_GAP;
                                r_sector_idx <= r_sector_idx + 32'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Fed with the same strobe that registers into out_iv, so its pulses
    // land in the same cycle as the byte they describe.
    frame_tracker u_frame_tracker (
        .clk          (clk),
        .rst          (rst),
        .i_byte_iv    (w_byte_iv),
        .i_byte_din   (sd_dout),
        .i_header_iv  (header_iv),
        .i_frame_size (frame_size),
        .o_frame_start(frame_start),
        .o_frame_done (frame_done),
        .o_sync_err   (sync_err),
        .o_plexer_rst (plexer_rst)
    );

    assign sd_rd   = r_sd_rd;
    assign sd_addr = r_sd_addr;
    assign out_iv  = r_out_iv;
    assign out_din = r_out_din;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_mp3_frame_sequencer.sv
// Randomised bench for mp3_frame_sequencer: an SD controller model replays a
// built byte file, and a monitor checks every forwarded byte against a frame model.
module tb_mp3_frame_sequencer;

    localparam logic [31:0] START_ADDR  = 32'h0000_2000;
    localparam int          NUM_SECTORS = 3;
    localparam int          TOTAL       = NUM_SECTORS * 512;
    localparam int          BUDGET      = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ds_ready;
    logic        sd_ready;
    logic        sd_byte_available;
    logic [7:0]  sd_dout;
    logic        header_iv;
    logic [10:0] frame_size;
    logic        sd_rd;
    logic [31:0] sd_addr;
    logic        out_iv;
    logic [7:0]  out_din;
    logic        frame_start;
    logic        frame_done;
    logic        plexer_rst;
    logic        sync_err;
    logic        busy;
    logic        done;

    logic [7:0]  stream  [TOTAL];
    logic        hdr_en  [TOTAL];
    logic [10:0] hdr_val [TOTAL];
    logic [11:0] exp_q[$];
    logic [31:0] addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int out_cnt  = 0;
    int bp       = 0;

    mp3_frame_sequencer #(
        .START_ADDR (START_ADDR),
        .NUM_SECTORS(NUM_SECTORS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .ds_ready         (ds_ready),
        .sd_ready         (sd_ready),
        .sd_byte_available(sd_byte_available),
        .sd_dout          (sd_dout),
        .header_iv        (header_iv),
        .frame_size       (frame_size),
        .sd_rd            (sd_rd),
        .sd_addr          (sd_addr),
        .out_iv           (out_iv),
        .out_din          (out_din),
        .frame_start      (frame_start),
        .frame_done       (frame_done),
        .plexer_rst       (plexer_rst),
        .sync_err         (sync_err),
        .busy             (busy),
        .done             (done)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Stream builder
    task automatic add_junk(input int n);
        for (int i = 0; i < n; i++) begin
            if (bp < TOTAL) stream[bp] = 8'($urandom_range(0, 254));
            bp++;
        end
    endtask

    task automatic add_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input int hdr_at, input int sz, input int len);
        int s;
        s = bp;
        add_junk(len);
        stream[s]     = b0;
        stream[s + 1] = b1;
        if (hdr_at > 0) begin
            hdr_en[s + hdr_at - 1]  = 1'b1;
            hdr_val[s + hdr_at - 1] = 11'(sz);
        end
    endtask

    task automatic build_stream();
        for (int i = 0; i < TOTAL; i++) begin
            hdr_en[i]  = 1'b0;
            hdr_val[i] = 11'd0;
        end
        bp = 0;
        add_frame(8'hFF, 8'hFB, 4, 417, 417);
        stream[2] = 8'h92;
        stream[3] = 8'h64;
        begin
            int s2, s4, s7, s8;
            s2 = $urandom_range(150, 300);
            s4 = $urandom_range(100, 200);
            s7 = $urandom_range(60, 200);
            s8 = $urandom_range(60, 200);
            add_frame(8'hFF, 8'hFB, $urandom_range(2, 4), s2, s2);
            add_frame(8'h00, 8'hFB, 0, 0, 10);       // corrupted first byte
            add_junk(20);
            add_frame(8'hFF, 8'hFB, 3, s4, s4);
            add_frame(8'hFF, 8'hF3, 0, 0, 30);       // header never arrives
            add_junk(10);
            add_frame(8'hFF, 8'hFA, 3, 3, 20);       // undersized frame_size
            add_frame(8'hFF, 8'hFB, 2, s7, s7);      // header with the locking byte
            add_frame(8'hFF, 8'hFB, 4, s8, s8);
        end
        add_junk(TOTAL - bp);
    endtask

    // Reference model: walks the file byte by byte in frame-position terms.
    task automatic load_expect();
        bit locked, prev_ff, fs, fd, err;
        int size, have_bytes, pos;
        logic [7:0] b;
        locked = 0; prev_ff = 0; size = 0; have_bytes = 0;
        for (int k = 0; k < TOTAL; k++) begin
            b = stream[k];
            fs = 0; fd = 0; err = 0;
            if (!locked) begin
                if (prev_ff && b[7:5] == 3'b111) begin
                    locked = 1; have_bytes = 2; size = 0; prev_ff = 0;
                end else begin
                    prev_ff = (b == 8'hFF);
                end
            end else begin
                pos = have_bytes + 1;
                if (pos == 1 && b != 8'hFF) err = 1;
                else if (pos == 5 && size == 0) err = 1;
                else if (size != 0 && pos == size) begin
                    fd = 1; have_bytes = 0; size = 0;
                end else begin
                    fs = (pos == 1);
                    have_bytes = pos;
                end
            end
            if (err) begin
                locked = 0; prev_ff = 0; size = 0; have_bytes = 0;
            end
            if (hdr_en[k] && locked) begin
                if (hdr_val[k] < 11'd4) begin
                    err = 1; locked = 0; prev_ff = 0; size = 0; have_bytes = 0;
                end else begin
                    size = int'(hdr_val[k]);
                end
            end
            exp_q.push_back({err, err, fd, fs, b});
        end
        for (int n = 0; n < NUM_SECTORS; n++) addr_q.push_back(START_ADDR + 32'(n * 512));
    endtask

    // SD controller model
    int          sd_st = 0;
    int          sd_gap = 0;
    int          sd_sent = 0;
    logic [31:0] sd_base = 0;

    initial begin
        sd_ready          = 1'b1;
        sd_byte_available = 1'b0;
        sd_dout           = 8'd0;
        header_iv         = 1'b0;
        frame_size        = 11'd0;
        forever begin
            @(negedge clk);
            sd_byte_available = 1'b0;
            header_iv         = 1'b0;
            frame_size        = 11'($urandom_range(0, 2047));
            if (rst) begin
                sd_st    = 0;
                sd_ready = 1'b1;
            end else begin
                case (sd_st)
                    0: if (sd_rd) begin
                        sd_base = sd_addr - START_ADDR;
                        sd_st   = 1;
                    end
                    1: begin
                        sd_ready = 1'b0;
                        sd_gap   = $urandom_range(1, 3);
                        sd_sent  = 0;
                        sd_st    = 2;
                    end
                    2: begin
                        if (sd_gap > 0) sd_gap--;
                        else begin
                            int idx;
                            idx = int'(sd_base) + sd_sent;
                            if (idx < 0 || idx >= TOTAL) idx = 0;
                            sd_byte_available = 1'b1;
                            sd_dout           = stream[idx];
                            if (hdr_en[idx]) begin
                                header_iv  = 1'b1;
                                frame_size = hdr_val[idx];
                            end
                            sd_sent++;
                            sd_gap = $urandom_range(0, 2);
                            if (sd_sent == 512) sd_st = 3;
                        end
                    end
                    default: begin
                        sd_ready = 1'b1;
                        sd_st    = 0;
                    end
                endcase
            end
        end
    end

    // Scoreboard monitor
    initial begin
        logic prev_rd;
        logic [11:0] exp;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (out_iv) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("extra_byte");
                end else begin
                    exp = exp_q.pop_front();
                    check("byte{prst,err,done,start,din}",
                          {20'd0, plexer_rst, sync_err, frame_done, frame_start, out_din}, {20'd0, exp});
                end
            end else begin
                check("stray_pulse", {28'd0, plexer_rst, sync_err, frame_done, frame_start}, 32'd0);
            end
            if (sd_rd && !prev_rd) begin
                if (addr_q.size() == 0) fail_now("unexpected_sd_rd");
                else check("sd_addr", sd_addr, addr_q.pop_front());
            end
            prev_rd = sd_rd;
        end
    end

    // Driver tasks
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int k;
        k = 0;
        while (out_cnt < n && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        if (out_cnt < n) fail_now("timeout_waiting_bytes");
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        if (!done) fail_now("timeout_waiting_done");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        addr_q.delete();
        out_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sd_rd"}, sd_rd, 0);
        check({tag, "_sd_addr"}, sd_addr, 0);
        check({tag, "_out_iv"}, out_iv, 0);
        check({tag, "_out_din"}, out_din, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_plexer_rst"}, plexer_rst, 0);
        check({tag, "_sync_err"}, sync_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic check_end(input string tag);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        @(negedge clk);
        check({tag, "_byte_count"}, out_cnt, TOTAL);
        check({tag, "_exp_left"}, exp_q.size(), 0);
        check({tag, "_addr_left"}, addr_q.size(), 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        ds_ready = 1'b1;
        build_stream();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        load_expect();

        // Run 1: full file, with a downstream stall after the first sector
        @(negedge clk);
        pulse_start();
        wait_bytes(1);
        ds_ready = 1'b0;
        wait_bytes(512);
        repeat (20) begin
            @(negedge clk);
            check("stall_no_sd_rd", sd_rd, 0);
        end
        check("stall_busy", busy, 1);
        ds_ready = 1'b1;
        @(negedge clk);
        check("sd_rd_after_ds_ready", sd_rd, 1);
        wait_done();
        check_end("run1");

        // start is ignored once DONE
        pulse_start();
        repeat (10) begin
            @(negedge clk);
            check("done_ignores_start_rd", sd_rd, 0);
        end
        check("done_hold", done, 1);

        // Run 2: abandoned mid-sector by reset
        do_reset();
        load_expect();
        pulse_start();
        wait_bytes(700);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        @(negedge clk);
        exp_q.delete();
        addr_q.delete();
        out_cnt = 0;
        load_expect();
        rst = 1'b0;

        // Run 3: restart from the first sector
        @(negedge clk);
        pulse_start();
        begin
            int k;
            k = 0;
            while (!sd_rd && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (!sd_rd) fail_now("timeout_restart_sd_rd");
            else check("restart_sd_addr", sd_addr, START_ADDR);
        end
        wait_done();
        check_end("run3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mp3_frame_sequencer.md
# mp3_frame_sequencer

Sequences MP3 bitstream fetch from the SD card controller into the byte demultiplexer (`sd_plexer`). It issues 512-byte sector reads, forwards each byte as a one-cycle valid pulse, and paces reads at sector boundaries against downstream backpressure. It also tracks frame boundaries from the header parser's `frame_size`, and on sync loss it resets the demux and re-hunts for a sync word.

## Interface
- `START_ADDR`, default 0: byte address of the first sector; must be a multiple of 512.
- `NUM_SECTORS`, default 1024: file length in sectors.
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins playback fetch.
- `ds_ready`, in, 1: downstream can absorb a full sector (512 bytes).
- `sd_ready`, in, 1: SD controller idle.
- `sd_byte_available`, in, 1: one-cycle pulse, `sd_dout` valid.
- `sd_dout`, in, 8: byte from SD.
- `header_iv`, in, 1: header parser valid pulse.
- `frame_size`, in, 11: frame length in bytes, including header.
- `sd_rd`, out, 1: read request.
- `sd_addr`, out, 32: read byte address.
- `out_iv`, out, 1: one-cycle byte valid to demux.
- `out_din`, out, 8: byte to demux.
- `frame_start`, out, 1: pulse coincident with `out_iv` of a frame's first byte.
- `frame_done`, out, 1: pulse coincident with `out_iv` of a frame's last byte.
- `plexer_rst`, out, 1: one-cycle demux reset on sync loss.
- `sync_err`, out, 1: one-cycle pulse on sync loss.
- `busy`, out, 1: high in any state except IDLE and DONE.
- `done`, out, 1: level, high after the last sector has streamed.

## Operation
- States:
  - IDLE: on `start`, go to GAP.
  - GAP: if `ds_ready` and `sd_ready`, go to ISSUE.
  - ISSUE: hold `sd_rd`=1 until `sd_ready`=0, then go to STREAM.
  - STREAM: count 512 byte pulses. After the 512th, if `sector_idx`==`NUM_SECTORS`-1 go to DONE, else increment `sector_idx` and go to GAP.
  - DONE: stays until `rst`. `start` is ignored outside IDLE.
- `sd_addr` = `START_ADDR` + 512·`sector_idx`. It is held stable from ISSUE entry until `sd_ready` returns high.
- Frame tracker modes: HUNT (the initial mode) and LOCK.
  - HUNT: a byte 0xFF followed by a byte with [7:5]=111 declares lock. `frame_start` is emitted retroactively for neither byte. The frame byte count is set to 2 and tracking proceeds.
  - LOCK: `fcnt` (11-bit) increments per `out_iv`. `frame_size` is latched on `header_iv`.
  - When `fcnt`==latched size−1 on a byte: `frame_done` fires and `fcnt` is cleared.
  - The next byte is the next frame's first byte: it must be 0xFF and `frame_start` fires with it.
  - If that first byte is not 0xFF: `sync_err` and `plexer_rst` pulse, and the tracker enters HUNT.
- `header_iv` must arrive before the frame's 5th byte. If it does not, the result is `sync_err` plus HUNT.
- `header_iv` while in HUNT is ignored.
- The sector stream is never interrupted by the frame tracker; frames straddle sectors freely.

## Timing
- Every output resets to 0. Internal state resets to IDLE/HUNT, `sector_idx`=0 and `fcnt`=0. Reset mid-STREAM abandons the sector; the SD controller is reset by the same `rst`.
- `out_iv`/`out_din` are registered and appear one cycle after `sd_byte_available`. `frame_start`, `frame_done`, `sync_err` and `plexer_rst` are registered in the same cycle as the `out_iv` that triggers them.
- `sd_rd` asserts the cycle after GAP sees both readies.
- Simultaneous `header_iv` and byte: the byte is counted first, then the size latched. A match check on that same byte uses the old size.
- `frame_size` < 4 or 0 when latched: treated as sync loss.

## Structure
- Shared package `mp3_pkg`: `SECTOR_BYTES`=512, the `SYNC_BYTE`=8'hFF constant, and the `fetch_state_t` and `sync_mode_t` enums.
- One natural submodule: `frame_tracker`, holding the HUNT/LOCK logic, `fcnt` and the size latch. It consumes `out_iv`/`out_din`.

## Test plan
- `NUM_SECTORS`=2, `ds_ready`=1, `start`: expect `sd_addr` 0 then 512, 1024 `out_iv` pulses, then `done`=1 and `busy`=0.
- `ds_ready`=0 after the first sector: expect no `sd_rd`, stall in GAP. Raise `ds_ready`: expect `sd_rd` next cycle.
- Stream 0xFFFB9264… with `header_iv` and `frame_size`=417 after byte 4:
  - `frame_done` on byte 417.
  - `frame_start` on byte 418 (0xFF).
- Corrupt byte 418 to 0x00: expect `sync_err` and `plexer_rst` pulses. Tracker relocks on the next 0xFF,0xFB pair.
- Withhold `header_iv` through byte 5: expect `sync_err` on byte 5.
- Assert `rst` mid-sector, then `start`: expect a restart at `sd_addr`=`START_ADDR` with `fcnt` cleared.
